// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl shared definitions.
// State encodings, width defaults, alignment helper.
package mem_stage_ctrl_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] MS_IDLE = 2'd0;
  localparam logic [1:0] MS_REQ  = 2'd1;
  localparam logic [1:0] MS_WAIT = 2'd2;

  function automatic logic word_aligned(
    input logic [1:0] lsb
  );
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl.sv
// MEM stage: passthrough to WB, or a cache
// access sequenced IDLE -> REQ -> WAIT.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_write_in,
  input  logic              is_load_in,
  input  logic              is_store_in,
  input  logic [ADDR_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [4:0]        register_d_in,
  output logic              req_valid,
  output logic              req_write,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  input  logic              req_ready,
  input  logic              resp_valid,
  input  logic [DATA_W-1:0] resp_rdata,
  output logic              stall_out,
  output logic              align_fault,
  output logic              wb_write_out,
  output logic [4:0]        wb_register_d_out,
  output logic [DATA_W-1:0] wb_data_out
);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [4:0]        r_rd;
  logic              r_is_write;
  logic              r_is_store;
  logic              r_fault;

  logic w_idle;
  logic w_req;
  logic w_wait;
  logic w_mem_op;
  logic w_aligned;
  logic w_take;
  logic w_fault;
  logic w_done;
  logic w_sel_pass;
  logic w_sel_load;
  logic w_sel_bub;
  logic [DATA_W-1:0] w_alu_wb;

  assign w_idle    = (r_state == MS_IDLE);
  assign w_req     = (r_state == MS_REQ);
  assign w_wait    = (r_state == MS_WAIT);
  assign w_mem_op  = is_load_in | is_store_in;
  assign w_aligned = word_aligned(
    alu_result_in[1:0]);
  assign w_take    = w_idle & w_mem_op
                   & w_aligned;
  assign w_fault   = w_idle & w_mem_op
                   & ~w_aligned;
  assign w_done    = w_wait & resp_valid;
  assign w_alu_wb  = DATA_W'(alu_result_in);

  // Exactly one of these retires each edge.
  assign w_sel_pass = w_idle & ~w_mem_op;
  assign w_sel_load = w_done & ~r_is_store;
  assign w_sel_bub  = ~(w_sel_pass
                      | w_sel_load);

  assign req_valid   = w_req;
  assign req_write   = r_is_store;
  assign req_addr    = r_addr;
  assign req_wdata   = r_wdata;
  assign align_fault = r_fault;
  assign stall_out   = w_take | w_req
                     | (w_wait & ~resp_valid);

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      w_idle: begin
        if (w_take) w_next = MS_REQ;
      end
      w_req: begin
        if (req_ready) w_next = MS_WAIT;
      end
      w_wait: begin
        if (resp_valid) w_next = MS_IDLE;
      end
      default: w_next = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MS_IDLE;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fault <= w_fault;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= '0;
      r_is_write <= 1'b0;
      r_is_store <= 1'b0;
    end else if (w_take) begin
      r_addr     <= {alu_result_in[ADDR_W-1:2],
                     2'b00};
      r_wdata    <= store_data_in;
      r_rd       <= register_d_in;
      r_is_write <= is_write_in;
      r_is_store <= is_store_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_write_out      <= 1'b0;
      wb_register_d_out <= '0;
      wb_data_out       <= '0;
    end else begin
      unique case (1'b1)
        w_sel_pass: begin
          wb_write_out      <= is_write_in
                             && register_d_in != 5'd0;
          wb_register_d_out <= register_d_in;
          wb_data_out       <= w_alu_wb;
        end
        w_sel_load: begin
          wb_write_out      <= r_is_write
                             && r_rd != 5'd0;
          wb_register_d_out <= r_rd;
          wb_data_out       <= resp_rdata;
        end
        w_sel_bub: begin
          wb_write_out      <= 1'b0;
        end
        default: begin
          wb_write_out      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: vector table,
// directed access sequences, random stream.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        is_write_in;
  logic        is_load_in;
  logic        is_store_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [4:0]  register_d_in;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        stall_out;
  logic        align_fault;
  logic        wb_write_out;
  logic [4:0]  wb_register_d_out;
  logic [31:0] wb_data_out;

  always #5 clk = ~clk;

  mem_stage_ctrl #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .is_write_in      (is_write_in),
    .is_load_in       (is_load_in),
    .is_store_in      (is_store_in),
    .alu_result_in    (alu_result_in),
    .store_data_in    (store_data_in),
    .register_d_in    (register_d_in),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .stall_out        (stall_out),
    .align_fault      (align_fault),
    .wb_write_out     (wb_write_out),
    .wb_register_d_out(wb_register_d_out),
    .wb_data_out      (wb_data_out)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h",
                  nm, act, exp);
  endtask

  task automatic drive(input logic w,
                       input logic l,
                       input logic s,
                       input logic [31:0] alu,
                       input logic [31:0] sd,
                       input logic [4:0] rd);
    is_write_in   = w;
    is_load_in    = l;
    is_store_in   = s;
    alu_result_in = alu;
    store_data_in = sd;
    register_d_in = rd;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic        w, l, s;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        e_wr, e_f;
  } vec_t;

  vec_t tbl[8];

  // One memory instruction held upstream until
  // its response cycle; starts/ends at negedge.
  task automatic mem_seq(input logic st,
                         input logic ld,
                         input logic w,
                         input logic [4:0] rd,
                         input logic [31:0] addr,
                         input logic [31:0] wd,
                         input logic [31:0] rdat,
                         input int rdly,
                         input int vdly);
    logic e_wr;
    e_wr = ld && !st && w && rd != 0;
    drive(w, ld, st, addr, wd, rd);
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    #1;
    chk("seq_stall_c0", stall_out, 1);
    chk("seq_rv_c0", req_valid, 0);
    @(posedge clk);
    for (int i = 0; i <= rdly; i++) begin
      @(negedge clk);
      req_ready  = (i == rdly);
      resp_valid = (i == 0 && rdly > 0);
      resp_rdata = 32'hBAD0BAD0;
      #1;
      chk("seq_rv", req_valid, 1);
      chk("seq_rwr", req_write, st);
      chk("seq_addr", req_addr, addr);
      if (st) chk("seq_wdata", req_wdata, wd);
      chk("seq_stall_req", stall_out, 1);
      @(posedge clk);
    end
    for (int j = 0; j <= vdly; j++) begin
      @(negedge clk);
      req_ready  = 1'b0;
      resp_valid = (j == vdly);
      resp_rdata = (j == vdly) ? rdat
                              : 32'h0BADF00D;
      #1;
      chk("seq_rv_wait", req_valid, 0);
      chk("seq_stall_wait", stall_out,
          (j != vdly));
      @(posedge clk);
    end
    @(negedge clk);
    resp_valid = 1'b0;
    nop();
    chk("seq_wb_wr", wb_write_out, e_wr);
    if (ld && !st)
      chk("seq_wb_data", wb_data_out, rdat);
    if (e_wr)
      chk("seq_wb_rd", wb_register_d_out, rd);
    chk("seq_fault", align_fault, 0);
  endtask

  // Instruction-level reference model state.
  logic        c_w, c_l, c_s;
  logic [31:0] c_alu, c_sd;
  logic [4:0]  c_rd;
  int          age;
  bit          hs, need, mem, al;
  bit          exp_rv, exp_st, cons;
  bit          e_v, e_wr, e_f, e_cd, e_cr;
  logic [31:0] e_data;
  logic [4:0]  e_rd;
  int          k;

  task automatic check_exp();
    if (e_v) begin
      chk("rnd_wb_wr", wb_write_out, e_wr);
      chk("rnd_fault", align_fault, e_f);
      if (e_cd)
        chk("rnd_wb_data", wb_data_out, e_data);
      if (e_cr)
        chk("rnd_wb_rd", wb_register_d_out, e_rd);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 0, 0, 32'h1234,     5,  1, 0};
    tbl[1] = '{0, 0, 0, 32'hFFFF0000, 5,  0, 0};
    tbl[2] = '{1, 0, 0, 32'h55,       0,  0, 0};
    tbl[3] = '{1, 0, 0, 32'hFFFFFFFF, 31, 1, 0};
    tbl[4] = '{1, 1, 0, 32'h102,      3,  0, 1};
    tbl[5] = '{0, 0, 1, 32'h41,       2,  0, 1};
    tbl[6] = '{1, 1, 1, 32'h3,        8,  0, 1};
    tbl[7] = '{1, 0, 0, 32'h7,        9,  1, 0};

    reset      = 1'b1;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    nop();
    repeat (2) @(negedge clk);
    chk("rst_rv", req_valid, 0);
    chk("rst_rwr", req_write, 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_wdata", req_wdata, 0);
    chk("rst_stall", stall_out, 0);
    chk("rst_fault", align_fault, 0);
    chk("rst_wb_wr", wb_write_out, 0);
    chk("rst_wb_rd", wb_register_d_out, 0);
    chk("rst_wb_data", wb_data_out, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].w, tbl[i].l, tbl[i].s,
            tbl[i].alu, 32'hCAFE0000,
            tbl[i].rd);
      #1;
      chk("tbl_stall", stall_out, 0);
      chk("tbl_rv", req_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk("tbl_wb_wr", wb_write_out, tbl[i].e_wr);
      chk("tbl_fault", align_fault, tbl[i].e_f);
      if (!tbl[i].l && !tbl[i].s) begin
        chk("tbl_wb_data", wb_data_out,
            tbl[i].alu);
        chk("tbl_wb_rd", wb_register_d_out,
            tbl[i].rd);
      end
    end
    nop();
    @(posedge clk);
    @(negedge clk);
    chk("tbl_fault_clr", align_fault, 0);

    mem_seq(0, 1, 1, 7, 32'h100, 32'h0,
            32'hDEADBEEF, 2, 2);
    mem_seq(1, 0, 0, 3, 32'h40, 32'hA5A5A5A5,
            32'h0, 3, 0);
    mem_seq(0, 1, 1, 0, 32'h200, 32'h0,
            32'h13572468, 0, 1);
    mem_seq(1, 1, 1, 9, 32'h80, 32'h5A5A0F0F,
            32'h77777777, 1, 1);
    mem_seq(0, 1, 0, 12, 32'hFFC, 32'h0,
            32'h24681357, 0, 0);

    drive(1, 1, 0, 32'h300, 32'h0, 6);
    req_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_ready = 1'b0;
    #2;
    reset = 1'b1;
    nop();
    #1;
    chk("mid_rst_rv", req_valid, 0);
    chk("mid_rst_stall", stall_out, 0);
    chk("mid_rst_addr", req_addr, 0);
    chk("mid_rst_wb_wr", wb_write_out, 0);
    chk("mid_rst_wb_data", wb_data_out, 0);
    @(negedge clk);
    reset      = 1'b0;
    drive(0, 0, 0, 32'h77, 32'h0, 1);
    resp_valid = 1'b1;
    resp_rdata = 32'h11111111;
    #1;
    chk("stale_stall", stall_out, 0);
    chk("stale_rv", req_valid, 0);
    @(posedge clk);
    @(negedge clk);
    resp_valid = 1'b0;
    chk("stale_wb_wr", wb_write_out, 0);
    chk("stale_wb_data", wb_data_out, 32'h77);
    drive(1, 0, 0, 32'hABC, 32'h0, 4);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_wb_wr", wb_write_out, 1);
    chk("post_rst_wb_rd", wb_register_d_out, 4);
    chk("post_rst_wb_data", wb_data_out,
        32'hABC);

    need = 1;
    e_v  = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      check_exp();
      if (need) begin
        k   = $urandom_range(0, 9);
        c_l = (k >= 4 && k < 7) || k == 9;
        c_s = (k >= 7);
        c_w = ($urandom_range(0, 3) != 0);
        c_alu = $urandom;
        if ((c_l || c_s)
            && $urandom_range(0, 4) != 0)
          c_alu[1:0] = 2'b00;
        c_sd = $urandom;
        c_rd = ($urandom_range(0, 7) == 0)
             ? 5'd0
             : 5'($urandom_range(1, 31));
        need = 0;
        age  = 0;
        hs   = 0;
      end
      drive(c_w, c_l, c_s, c_alu, c_sd, c_rd);
      mem = c_l || c_s;
      al  = mem && (c_alu[1:0] == 2'b00);
      req_ready = 1'($urandom_range(0, 1));
      if (al && hs)
        resp_valid = ($urandom_range(0, 2) == 0);
      else
        resp_valid = ($urandom_range(0, 5) == 0);
      resp_rdata = $urandom;
      #1;
      exp_rv = al && age >= 1 && !hs;
      exp_st = al && !(hs && resp_valid);
      chk("rnd_rv", req_valid, exp_rv);
      chk("rnd_stall", stall_out, exp_st);
      if (exp_rv) begin
        chk("rnd_rwr", req_write, c_s);
        chk("rnd_addr", req_addr, c_alu);
        if (c_s)
          chk("rnd_wdata", req_wdata, c_sd);
      end
      cons = !exp_st;
      e_v  = 1;
      e_f  = mem && !al;
      e_wr = 0;
      e_cd = 0;
      e_cr = 0;
      if (cons && !mem) begin
        e_wr   = c_w && c_rd != 0;
        e_data = c_alu;
        e_rd   = c_rd;
        e_cd   = 1;
        e_cr   = 1;
      end else if (cons && al && !c_s) begin
        e_wr   = c_w && c_rd != 0;
        e_data = resp_rdata;
        e_rd   = c_rd;
        e_cd   = 1;
        e_cr   = e_wr;
      end
      if (exp_rv && req_ready) hs = 1;
      age++;
      if (cons) need = 1;
      @(posedge clk);
      @(negedge clk);
    end
    check_exp();

    $display("%0d/%0d checks passed",
             n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller that consumes the EX/MEM pipeline register outputs and produces the MEM/WB stage inputs. Non-memory instructions pass through to writeback in one cycle. Loads and stores are sequenced against the data cache with a valid/ready request and a separate response. The upstream pipeline is stalled until the access completes.

## Interface
Parameters
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `is_write_in`  in  1  instruction writes `register_d_in`.
- `is_load_in`  in  1  load instruction.
- `is_store_in`  in  1  store instruction.
- `alu_result_in`  in  ADDR_W  ALU result, or the effective address for memory operations.
- `store_data_in`  in  DATA_W  store data.
- `register_d_in`  in  5  destination register.
- `req_valid`  out  1  cache request valid.
- `req_write`  out  1  1 = store, 0 = load.
- `req_addr`  out  ADDR_W  word-aligned address.
- `req_wdata`  out  DATA_W  store data.
- `req_ready`  in  1  cache accepts the request.
- `resp_valid`  in  1  cache access complete.
- `resp_rdata`  in  DATA_W  load data.
- `stall_out`  out  1  hold the EX/MEM register and everything upstream.
- `align_fault`  out  1  one-cycle pulse: misaligned memory operation.
- `wb_write_out`  out  1  registered: write the register file.
- `wb_register_d_out`  out  5  registered destination register.
- `wb_data_out`  out  DATA_W  registered writeback data.

## Operation
- FSM states: `IDLE`, `REQ`, `WAIT`.
- Define `mem_op = is_load_in | is_store_in`.

IDLE
- If `!mem_op`, register the passthrough on the next edge:
  - `wb_write_out <= is_write_in && register_d_in != 0`
  - `wb_data_out <= alu_result_in`
  - `wb_register_d_out <= register_d_in`
- If `mem_op` and `alu_result_in[1:0] != 0`:
  - pulse `align_fault` on the next edge;
  - set `wb_write_out <= 0`;
  - issue no cache request and stay in IDLE.
- If `mem_op` and the address is aligned:
  - latch address, store data, `register_d_in`, `is_write_in` and the op type;
  - go to REQ.
- If `is_load_in` and `is_store_in` are both high, the store wins.

REQ
- `req_valid = 1`, and `req_*` come from the latched registers.
- They stay stable until `req_ready`.
- On `req_valid && req_ready`, go to WAIT.
- `resp_valid` seen in REQ is ignored.

WAIT
- On `resp_valid`, go to IDLE.
- For a load: `wb_data_out <= resp_rdata` and `wb_write_out <= latched is_write && rd != 0`.
- For a store: `wb_write_out <= 0`.

General rules
- `stall_out` is combinational: `(IDLE && mem_op && aligned) || REQ || (WAIT && !resp_valid)`.
- `wb_write_out = 0` on every edge that completes nothing (bubble).
- A misaligned op does not stall. It retires as a bubble in one cycle.

## Timing
- Reset values: state IDLE. `req_valid`, `req_write`, `req_addr`, `req_wdata`, `stall_out`, `align_fault`, `wb_write_out`, `wb_register_d_out`, `wb_data_out` are all 0.
- Passthrough latency: 1 cycle.
- Memory op presented in cycle 0, with `req_ready` high in cycle 1 and `resp_valid` high in cycle 2:
  - `stall_out` is high in cycles 0–1 and low in cycle 2;
  - `req_valid` is high in cycle 1;
  - WB outputs are valid in cycle 3.
- Each additional cycle without `req_ready` or `resp_valid` extends the stall by one cycle.
- The upstream register advances on the edge that ends the `resp_valid` cycle. The next instruction is sampled in IDLE on the following cycle.
- Reset mid-access drops `req_valid` immediately and returns to IDLE. A stale `resp_valid` arriving afterwards in IDLE is ignored.

## Structure
- Shared package/include holds:
  - FSM state encodings (`MS_IDLE`, `MS_REQ`, `MS_WAIT`, 2 bits);
  - the `ADDR_W`/`DATA_W` defaults.
- Single module, no sub-module. The WB output register is inline, written from a one-hot "complete" select (passthrough / load response / bubble).

## Test plan
- Passthrough: `is_write_in=1`, `rd=5`, `alu_result_in=0x1234` -> next cycle `wb_write_out=1`, `wb_register_d_out=5`, `wb_data_out=0x1234`, `stall_out` never high.
- Load: addr `0x100`, `rd=7`, `req_ready` delayed 2 cycles, `resp_valid` 3 cycles later with `resp_rdata=0xDEADBEEF` -> `req_addr=0x100`, `req_write=0`, `stall_out` high until the response cycle, then `wb_write_out=1`, `wb_register_d_out=7`, `wb_data_out=0xDEADBEEF`.
- Store: addr `0x40`, data `0xA5A5A5A5` -> `req_write=1`, `req_wdata=0xA5A5A5A5` held stable while `req_ready=0`; on completion `wb_write_out=0`.
- Misaligned load at `0x102` -> `align_fault` pulses once, `req_valid` stays 0, no stall, `wb_write_out=0`.
- Load to `rd=0` -> access is performed, `wb_write_out=0`.
- Reset asserted in WAIT, then a `resp_valid` pulse after deassert -> all outputs 0, state IDLE, response ignored, next passthrough instruction behaves normally.
